// File: rtl/hall_call_scheduler.sv
// Hall-call scheduler: pending up/down call bitmaps, round-robin slot selection, two-car dispatch.
// Optional feature macro UPPEAK_LOBBY_PRIORITY_EN: lobby up call preempts round-robin in up-peak.
module hall_call_scheduler #(
  parameter int NUM_FLOORS  = 8,
  parameter int ACK_TIMEOUT = 15
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       call_valid,
  input  logic [2:0] call_floor,
  input  logic       call_dir,
  input  logic [1:0] traffic_state,
  input  logic [2:0] elev_floor_1,
  input  logic [2:0] elev_floor_2,
  input  logic       elev_idle_1,
  input  logic       elev_idle_2,
  output logic [1:0] dispatch_valid,
  output logic [2:0] dispatch_floor,
  output logic       dispatch_dir,
  input  logic [1:0] dispatch_ack,
  output logic [7:0] pending_up,
  output logic [7:0] pending_dn,
  output logic       timeout_pulse
);
  localparam int NUM_SLOTS = 2 * NUM_FLOORS;
  localparam int CW = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
  localparam logic [3:0] FLOOR_LIMIT = 4'(NUM_FLOORS);
  localparam logic [2:0] TOP_FLOOR = 3'(NUM_FLOORS - 1);
  localparam logic [3:0] LAST_SLOT = 4'(NUM_SLOTS - 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(ACK_TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, SELECT, ASSIGN, ISSUE} state_t;

  state_t          state_reg, state_next;
  logic [15:0]     pending_reg, pending_next;
  logic [3:0]      ptr_reg, ptr_next;
  logic [3:0]      slot_reg, slot_next;
  logic [1:0]      dvalid_reg, dvalid_next;
  logic [2:0]      dfloor_reg, dfloor_next;
  logic            ddir_reg, ddir_next;
  logic            timeout_reg, timeout_next;
  logic [CW-1:0]   cnt_reg, cnt_next;

  // Returns {found, slot}: first set slot at or after ptr, wrapping past the top slot.
  function automatic logic [4:0] rr_pick(input logic [15:0] bits, input logic [3:0] ptr);
    logic [4:0] res;
    logic [4:0] idx;
    res = 5'd0;
    for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
      idx = {1'b0, ptr} + 5'(i);
      if (idx >= 5'(NUM_SLOTS)) idx = idx - 5'(NUM_SLOTS);
      if (bits[idx[3:0]]) res = {1'b1, idx[3:0]};
    end
    return res;
  endfunction

  logic        call_ok;
  logic [15:0] set_mask;
  logic [4:0]  rr_result;
  logic [3:0]  slot_inc;
  logic [2:0]  dist_1, dist_2;
  logic        pick_2;
  logic        ack_hit;
  logic        lobby_priority;

  assign call_ok = call_valid && ({1'b0, call_floor} < FLOOR_LIMIT)
                   && !(call_dir && call_floor == TOP_FLOOR)
                   && !(!call_dir && call_floor == 3'd0);
  assign set_mask  = call_ok ? (16'd1 << {call_floor, call_dir}) : 16'd0;
  assign rr_result = rr_pick(pending_reg, ptr_reg);
  assign slot_inc  = (slot_reg == LAST_SLOT) ? 4'd0 : slot_reg + 4'd1;
  assign ack_hit   = |(dispatch_ack & dvalid_reg);

`ifdef UPPEAK_LOBBY_PRIORITY_EN
  assign lobby_priority = (traffic_state == 2'b01) && pending_reg[1];
`else
  logic traffic_unused;
  assign lobby_priority = 1'b0;
  assign traffic_unused = ^traffic_state;
`endif

  always_comb begin
    dist_1 = (elev_floor_1 >= slot_reg[3:1]) ? elev_floor_1 - slot_reg[3:1]
                                             : slot_reg[3:1] - elev_floor_1;
    dist_2 = (elev_floor_2 >= slot_reg[3:1]) ? elev_floor_2 - slot_reg[3:1]
                                             : slot_reg[3:1] - elev_floor_2;
    // A lone idle car wins outright; otherwise nearest car, ties to car 1.
    if (elev_idle_1 != elev_idle_2) pick_2 = elev_idle_2;
    else                            pick_2 = (dist_2 < dist_1);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg   <= IDLE;
      pending_reg <= 16'd0;
      ptr_reg     <= 4'd0;
      slot_reg    <= 4'd0;
      dvalid_reg  <= 2'b00;
      dfloor_reg  <= 3'd0;
      ddir_reg    <= 1'b0;
      timeout_reg <= 1'b0;
      cnt_reg     <= '0;
    end else begin
      state_reg   <= state_next;
      pending_reg <= pending_next;
      ptr_reg     <= ptr_next;
      slot_reg    <= slot_next;
      dvalid_reg  <= dvalid_next;
      dfloor_reg  <= dfloor_next;
      ddir_reg    <= ddir_next;
      timeout_reg <= timeout_next;
      cnt_reg     <= cnt_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    pending_next = pending_reg | set_mask;
    ptr_next     = ptr_reg;
    slot_next    = slot_reg;
    dvalid_next  = dvalid_reg;
    dfloor_next  = dfloor_reg;
    ddir_next    = ddir_reg;
    timeout_next = 1'b0;
    cnt_next     = cnt_reg;
    case (state_reg)
      IDLE: begin
        if (|pending_reg) state_next = SELECT;
      end
      SELECT: begin
        if (lobby_priority) begin
          slot_next  = 4'd1;
          state_next = ASSIGN;
        end else if (rr_result[4]) begin
          slot_next  = rr_result[3:0];
          state_next = ASSIGN;
        end else begin
          state_next = IDLE;
        end
      end
      ASSIGN: begin
        dvalid_next = pick_2 ? 2'b10 : 2'b01;
        dfloor_next = slot_reg[3:1];
        ddir_next   = slot_reg[0];
        cnt_next    = '0;
        state_next  = ISSUE;
      end
      ISSUE: begin
        if (ack_hit) begin
          // A new call landing on this edge re-sets the bit after the clear.
          pending_next = (pending_reg & ~(16'd1 << slot_reg)) | set_mask;
          ptr_next     = slot_inc;
          dvalid_next  = 2'b00;
          state_next   = IDLE;
        end else if (cnt_reg == CNT_LAST) begin
          timeout_next = 1'b1;
          ptr_next     = slot_inc;
          dvalid_next  = 2'b00;
          state_next   = IDLE;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_bitmap
      assign pending_up[gi] = pending_reg[2*gi+1];
      assign pending_dn[gi] = pending_reg[2*gi];
    end
  endgenerate

  assign dispatch_valid = dvalid_reg;
  assign dispatch_floor = dfloor_reg;
  assign dispatch_dir   = ddir_reg;
  assign timeout_pulse  = timeout_reg;
endmodule

// File: doc/hall_call_scheduler.md
HALL_CALL_SCHEDULER -- requirements
Module: hall_call_scheduler

Interface
REQ-001 Parameter NUM_FLOORS, default 8, number of served floors; floors are encoded in 3 bits, so the maximum is 8.
REQ-002 Parameter ACK_TIMEOUT, default 15, maximum cycles to wait for a dispatch acknowledge.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 call_valid  input  1  a hall call is presented this cycle.
REQ-006 call_floor  input  3  floor of the presented call.
REQ-007 call_dir  input  1  direction of the call: 1=up, 0=down.
REQ-008 traffic_state  input  2  building traffic mode: 2'b01=up-peak, any other value=normal.
REQ-009 elev_floor_1, elev_floor_2  input  3 each  current floor of elevator 1 and elevator 2.
REQ-010 elev_idle_1, elev_idle_2  input  1 each  that elevator's queue is empty.
REQ-011 dispatch_valid  output  2  one-hot dispatch strobe; bit0=elevator 1, bit1=elevator 2.
REQ-012 dispatch_floor  output  3 / dispatch_dir  output  1  the call being dispatched.
REQ-013 dispatch_ack  input  2  per-elevator acceptance of the dispatch.
REQ-014 pending_up, pending_dn  output  8 each  pending-call bitmaps, indexed by floor.
REQ-015 timeout_pulse  output  1  one-cycle flag raised when a dispatch is abandoned.

Function
REQ-016 A call on call_valid SHALL set its bit in pending_up or pending_dn on the next edge.
- Repeat calls on an already-set bit merge into it.
- Calls with call_floor>=NUM_FLOORS are ignored.
- Up calls at floor NUM_FLOORS-1 and down calls at floor 0 are ignored.
REQ-017 Call slots SHALL be numbered slot=floor*2+dir.
REQ-018 The FSM SHALL have the states IDLE, SELECT, ASSIGN and ISSUE.
REQ-019 IDLE SHALL move to SELECT whenever any pending bit is set.
REQ-020 SELECT SHALL latch the first set slot at or after the round-robin pointer, wrapping at the top slot, then move to ASSIGN.
REQ-021 ASSIGN SHALL choose the target elevator in this order, then move to ISSUE:
- If exactly one elevator is idle, choose that one.
- Otherwise choose the smaller |elev_floor - call floor|.
- On a distance tie, choose elevator 1.
REQ-022 In ISSUE, dispatch_valid, dispatch_floor and dispatch_dir SHALL be held stable until an acknowledge or a timeout.
REQ-023 The acknowledge SHALL be taken only from dispatch_ack of the target elevator; an ack on the other bit is ignored.
REQ-024 On a valid acknowledge:
- clear the slot's bit;
- set the round-robin pointer to slot+1 modulo 2*NUM_FLOORS;
- deassert dispatch_valid on the next cycle;
- return to IDLE.
REQ-025 If no acknowledge arrives after ACK_TIMEOUT cycles in ISSUE:
- pulse timeout_pulse for one cycle;
- leave the slot's bit set;
- advance the round-robin pointer past the slot;
- return to IDLE.
REQ-026 If a new call for the slot being cleared arrives on the same edge as its acknowledge, the set SHALL win and the bit stays pending.
REQ-027 Latency from a call into an empty scheduler to dispatch_valid SHALL be 4 cycles: latch, SELECT, ASSIGN, ISSUE.
REQ-028 At most one dispatch_valid bit SHALL be high in any cycle.
REQ-029 Elevator floor and idle inputs SHALL be sampled only in ASSIGN.

Reset
REQ-030 While reset is low, the block SHALL asynchronously force:
- FSM to IDLE;
- pending_up, pending_dn and the round-robin pointer to 0;
- dispatch_valid to 2'b00;
- dispatch_floor and dispatch_dir to 0;
- timeout_pulse to 0;
- the timeout counter to 0.
REQ-031 If reset asserts mid-ISSUE, the in-flight dispatch SHALL be dropped without an acknowledge being required.

Configuration
REQ-032 With UPPEAK_LOBBY_PRIORITY_EN defined, when traffic_state==2'b01 and floor 0 up is pending, SELECT SHALL choose that slot regardless of the round-robin pointer.
REQ-033 Without UPPEAK_LOBBY_PRIORITY_EN, SELECT SHALL be pure round-robin in all traffic states.

Verification
REQ-034 Scenario: reset released; call floor 3 up; elevators at 0 and 6, both idle; ack on bit0 in the first ISSUE cycle.
- dispatch_valid=2'b01, floor 3, dir 1, high 4 cycles after the call.
- pending_up[3] clears after the ack.
REQ-035 Scenario: elevator 1 busy at floor 2, elevator 2 idle at floor 7; call floor 2 down.
- dispatch_valid=2'b10.
REQ-036 Scenario: calls at floor 1 up, 4 down and 6 up, each acked immediately.
- Dispatch order is 1 up, 4 down, 6 up.
- Order wraps correctly when a new floor 0 up call arrives afterwards.
REQ-037 Scenario: never ack a dispatch; ACK_TIMEOUT=15.
- timeout_pulse rises exactly once, 15 cycles after ISSUE entry.
- The call bit stays set and is re-dispatched later.
REQ-038 Scenario: macro defined, traffic_state=2'b01, pointer past slot 0, floors 5 up and 0 up pending.
- Floor 0 up dispatches first.
- With the macro undefined, floor 5 up dispatches first.
REQ-039 Scenario: call floor 7 up, call floor 0 down, and reset pulsed low mid-ISSUE.
- The two invalid calls leave both pending bitmaps unchanged.
- After the reset pulse, all outputs read 0 immediately, with no clock edge required.
